// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: grants the single-port data RAM to the CPU or debug port, one access at a time.
// Define MEM_ARB_ROUND_ROBIN_EN for round-robin tie-breaking; otherwise debug wins ties.
module mem_port_arbiter #(
    parameter int AW     = 5,
    parameter int DW     = 8,
    parameter int RD_LAT = 1
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          cpu_req,
    input  logic          cpu_we,
    input  logic [AW-1:0] cpu_addr,
    input  logic [DW-1:0] cpu_wdata,
    output logic [DW-1:0] cpu_rdata,
    output logic          cpu_ack,
    output logic          cpu_stall,
    input  logic          dbg_req,
    input  logic          dbg_we,
    input  logic [AW-1:0] dbg_addr,
    input  logic [DW-1:0] dbg_wdata,
    output logic [DW-1:0] dbg_rdata,
    output logic          dbg_ack,
    output logic          mem_en,
    output logic          mem_we,
    output logic [AW-1:0] mem_addr,
    output logic [DW-1:0] mem_wdata,
    input  logic [DW-1:0] mem_rdata,
    output logic          busy
);
    typedef enum logic [1:0] {IDLE, ISSUE, WAIT, ACK} state_t;

    state_t        state_q, state_d;
    logic          owner_q, owner_d;
    logic          we_q, we_d;
    logic [AW-1:0] addr_q, addr_d;
    logic [DW-1:0] wdata_q, wdata_d;
    logic [DW-1:0] cpu_rdata_q, cpu_rdata_d;
    logic [DW-1:0] dbg_rdata_q, dbg_rdata_d;
    logic [2:0]    cnt_q, cnt_d;
    logic          pick_dbg;

`ifdef MEM_ARB_ROUND_ROBIN_EN
    // last_q = 1 when the previous grant went to debug
    logic last_q, last_d;
    assign pick_dbg = dbg_req & (~cpu_req | ~last_q);
    assign last_d   = (state_q == IDLE && (cpu_req || dbg_req)) ? pick_dbg : last_q;
    always_ff @(posedge clk or posedge rst) begin
        if (rst) last_q <= 1'b1;
        else     last_q <= last_d;
    end
`else
    assign pick_dbg = dbg_req;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= IDLE;
            owner_q     <= 1'b0;
            we_q        <= 1'b0;
            addr_q      <= '0;
            wdata_q     <= '0;
            cpu_rdata_q <= '0;
            dbg_rdata_q <= '0;
            cnt_q       <= '0;
        end else begin
            state_q     <= state_d;
            owner_q     <= owner_d;
            we_q        <= we_d;
            addr_q      <= addr_d;
            wdata_q     <= wdata_d;
            cpu_rdata_q <= cpu_rdata_d;
            dbg_rdata_q <= dbg_rdata_d;
            cnt_q       <= cnt_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        owner_d     = owner_q;
        we_d        = we_q;
        addr_d      = addr_q;
        wdata_d     = wdata_q;
        cpu_rdata_d = cpu_rdata_q;
        dbg_rdata_d = dbg_rdata_q;
        cnt_d       = cnt_q;
        case (state_q)
            IDLE: if (cpu_req || dbg_req) begin
                owner_d = pick_dbg;
                we_d    = pick_dbg ? dbg_we : cpu_we;
                addr_d  = pick_dbg ? dbg_addr : cpu_addr;
                wdata_d = pick_dbg ? dbg_wdata : cpu_wdata;
                state_d = ISSUE;
            end
            ISSUE: begin
                state_d = we_q ? ACK : WAIT;
                cnt_d   = 3'(RD_LAT);
            end
            WAIT: begin
                cnt_d = cnt_q - 3'd1;
                if (cnt_q == 3'd1) begin
                    state_d     = ACK;
                    cpu_rdata_d = owner_q ? cpu_rdata_q : mem_rdata;
                    dbg_rdata_d = owner_q ? mem_rdata : dbg_rdata_q;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign mem_en    = state_q == ISSUE;
    assign mem_we    = mem_en & we_q;
    assign mem_addr  = addr_q;
    assign mem_wdata = wdata_q;
    assign cpu_ack   = state_q == ACK & ~owner_q;
    assign dbg_ack   = state_q == ACK & owner_q;
    assign cpu_stall = cpu_req & ~cpu_ack;
    assign cpu_rdata = cpu_rdata_q;
    assign dbg_rdata = dbg_rdata_q;
    assign busy      = state_q != IDLE;
endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb_mem_port_arbiter: scoreboard bench for mem_port_arbiter with a latency-pipelined memory model.
module tb_mem_port_arbiter;
    localparam int AW = 5, DW = 8, LAT = 2;

    logic clk = 1'b0;
    logic rst;
    logic cpu_req, cpu_we, dbg_req, dbg_we;
    logic [AW-1:0] cpu_addr, dbg_addr, mem_addr;
    logic [DW-1:0] cpu_wdata, dbg_wdata, cpu_rdata, dbg_rdata, mem_wdata, mem_rdata;
    logic cpu_ack, cpu_stall, dbg_ack, mem_en, mem_we, busy;

    always #5 clk = ~clk;

    mem_port_arbiter #(.AW(AW), .DW(DW), .RD_LAT(LAT)) dut (
        .clk(clk), .rst(rst),
        .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
        .cpu_rdata(cpu_rdata), .cpu_ack(cpu_ack), .cpu_stall(cpu_stall),
        .dbg_req(dbg_req), .dbg_we(dbg_we), .dbg_addr(dbg_addr), .dbg_wdata(dbg_wdata),
        .dbg_rdata(dbg_rdata), .dbg_ack(dbg_ack),
        .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_rdata(mem_rdata), .busy(busy)
    );

    typedef struct {
        logic          dbg;
        int            cyc;
        logic [DW-1:0] rd;
    } exp_t;

    exp_t sb[$];
    exp_t e_m;
    int n_cmp = 0, n_bad = 0, cyc = 0;
    logic [DW-1:0] cpu_rd_m = '0, dbg_rd_m = '0;

    function automatic logic [DW-1:0] rom(input logic [AW-1:0] a);
        return (a == 5'd3) ? 8'h3C : 8'(32'(a) * 13 + 1);
    endfunction

    // Read data appears LAT cycles after the strobe cycle, X otherwise
    logic [AW-1:0]  pa [LAT];
    logic [LAT-1:0] pv;
    always @(posedge clk) begin
        cyc   <= cyc + 1;
        pa[0] <= mem_addr;
        pv[0] <= rst ? 1'b0 : (mem_en && !mem_we);
        for (int i = 1; i < LAT; i++) begin
            pa[i] <= pa[i-1];
            pv[i] <= rst ? 1'b0 : pv[i-1];
        end
    end
    assign mem_rdata = pv[LAT-1] ? rom(pa[LAT-1]) : 8'hxx;

    always @(negedge clk) begin
        if (!rst && (cpu_ack || dbg_ack)) begin
            n_cmp++;
            if (sb.size() == 0) begin
                n_bad++;
                $display("FAIL ack_unexpected got cpu_ack=%0b dbg_ack=%0b at cyc=%0d, required no ack", cpu_ack, dbg_ack, cyc);
            end else begin
                e_m = sb.pop_front();
                if ((cpu_ack && dbg_ack) || dbg_ack !== e_m.dbg || cyc != e_m.cyc ||
                    (dbg_ack ? dbg_rdata : cpu_rdata) !== e_m.rd) begin
                    n_bad++;
                    $display("FAIL ack_check got dbg=%0b cyc=%0d rdata=%h, required dbg=%0b cyc=%0d rdata=%h",
                             dbg_ack, cyc, dbg_ack ? dbg_rdata : cpu_rdata, e_m.dbg, e_m.cyc, e_m.rd);
                end
            end
        end
    end

    task automatic test_reset;
        rst = 1'b1;
        cpu_req = 1'b1;
        repeat (2) @(negedge clk);
        n_cmp++;
        if ({mem_en, mem_we, busy, cpu_ack, dbg_ack} !== 5'b0) begin
            n_bad++;
            $display("FAIL reset_ctrl got %b required 00000", {mem_en, mem_we, busy, cpu_ack, dbg_ack});
        end
        n_cmp++;
        if ({mem_addr, mem_wdata, cpu_rdata, dbg_rdata} !== 29'd0) begin
            n_bad++;
            $display("FAIL reset_data got addr=%h wdata=%h cpu_rd=%h dbg_rd=%h required all 0", mem_addr, mem_wdata, cpu_rdata, dbg_rdata);
        end
        n_cmp++;
        if (cpu_stall !== 1'b1) begin
            n_bad++;
            $display("FAIL reset_stall_hi got %b required 1", cpu_stall);
        end
        cpu_req = 1'b0;
        #1;
        n_cmp++;
        if (cpu_stall !== 1'b0) begin
            n_bad++;
            $display("FAIL reset_stall_lo got %b required 0", cpu_stall);
        end
        rst = 1'b0;
    endtask

    task automatic test_cpu_write;
        int c0;
        @(posedge clk); #1;
        cpu_req = 1'b1; cpu_we = 1'b1; cpu_addr = 5'd5; cpu_wdata = 8'hA5;
        c0 = cyc;
        sb.push_back('{1'b0, c0 + 2, cpu_rd_m});
        @(negedge clk);
        n_cmp++;
        if ({cpu_stall, busy, mem_en} !== 3'b100) begin
            n_bad++;
            $display("FAIL wr_c0 got stall/busy/en=%b required 100", {cpu_stall, busy, mem_en});
        end
        @(negedge clk);
        n_cmp++;
        if ({mem_en, mem_we, mem_addr, mem_wdata, cpu_stall} !== {1'b1, 1'b1, 5'd5, 8'hA5, 1'b1}) begin
            n_bad++;
            $display("FAIL wr_issue got en=%b we=%b addr=%h wdata=%h stall=%b required 1 1 05 a5 1", mem_en, mem_we, mem_addr, mem_wdata, cpu_stall);
        end
        @(negedge clk);
        n_cmp++;
        if ({cpu_ack, cpu_stall, mem_en, mem_we} !== 4'b1000) begin
            n_bad++;
            $display("FAIL wr_ack got ack/stall/en/we=%b required 1000", {cpu_ack, cpu_stall, mem_en, mem_we});
        end
        cpu_req = 1'b0;
        @(negedge clk);
        n_cmp++;
        if ({cpu_ack, busy} !== 2'b00) begin
            n_bad++;
            $display("FAIL wr_after got ack/busy=%b required 00", {cpu_ack, busy});
        end
    endtask

    task automatic test_dbg_read;
        int c0;
        @(posedge clk); #1;
        dbg_req = 1'b1; dbg_we = 1'b0; dbg_addr = 5'd3; dbg_wdata = 8'hFF;
        c0 = cyc;
        dbg_rd_m = rom(5'd3);
        sb.push_back('{1'b1, c0 + 2 + LAT, dbg_rd_m});
        repeat (2) @(negedge clk);
        n_cmp++;
        if ({mem_en, mem_we, mem_addr} !== {1'b1, 1'b0, 5'd3}) begin
            n_bad++;
            $display("FAIL rd_issue got en=%b we=%b addr=%h required 1 0 03", mem_en, mem_we, mem_addr);
        end
        for (int k = 0; k < LAT; k++) begin
            @(negedge clk);
            n_cmp++;
            if ({busy, mem_en, dbg_ack, mem_addr} !== {1'b1, 1'b0, 1'b0, 5'd3}) begin
                n_bad++;
                $display("FAIL rd_wait%0d got busy=%b en=%b ack=%b addr=%h required 1 0 0 03", k, busy, mem_en, dbg_ack, mem_addr);
            end
        end
        @(negedge clk);
        n_cmp++;
        if ({dbg_ack, dbg_rdata, cpu_rdata} !== {1'b1, 8'h3C, cpu_rd_m}) begin
            n_bad++;
            $display("FAIL rd_ack got ack=%b dbg_rd=%h cpu_rd=%h required 1 3c %h", dbg_ack, dbg_rdata, cpu_rdata, cpu_rd_m);
        end
        dbg_req = 1'b0;
    endtask

    task automatic test_tie;
        int c0;
        logic first;
        logic [AW-1:0] a1, a2;
`ifdef MEM_ARB_ROUND_ROBIN_EN
        first = 1'b0;
`else
        first = 1'b1;
`endif
        a1 = first ? 5'd12 : 5'd10;
        a2 = first ? 5'd10 : 5'd12;
        @(posedge clk); #1;
        cpu_req = 1'b1; cpu_we = 1'b1; cpu_addr = 5'd10; cpu_wdata = 8'h11;
        dbg_req = 1'b1; dbg_we = 1'b1; dbg_addr = 5'd12; dbg_wdata = 8'h22;
        c0 = cyc;
        sb.push_back('{first, c0 + 2, first ? dbg_rd_m : cpu_rd_m});
        sb.push_back('{~first, c0 + 5, first ? cpu_rd_m : dbg_rd_m});
        for (int t = 0; t < 8; t++) begin
            @(negedge clk);
            if (t == 1 || t == 4) begin
                n_cmp++;
                if ({mem_en, mem_addr} !== {1'b1, (t == 1) ? a1 : a2}) begin
                    n_bad++;
                    $display("FAIL tie_issue%0d got en=%b addr=%h required 1 %h", t, mem_en, mem_addr, (t == 1) ? a1 : a2);
                end
            end
            if (cpu_ack) cpu_req = 1'b0;
            if (dbg_ack) dbg_req = 1'b0;
        end
    endtask

    task automatic test_back_to_back;
        int c0, ni, cn, dn, pc, pd;
        logic own [8];
        logic [DW-1:0] ew [8];
        pc = 0; pd = 0;
        for (int k = 0; k < 8; k++) begin
`ifdef MEM_ARB_ROUND_ROBIN_EN
            own[k] = k[0];
`else
            own[k] = k < 4;
`endif
            ew[k] = own[k] ? 8'(8'h80 + pd) : 8'(8'h40 + pc);
            if (own[k]) pd++; else pc++;
        end
        @(posedge clk); #1;
        cpu_req = 1'b1; cpu_we = 1'b1; cpu_addr = 5'd16; cpu_wdata = 8'h40;
        dbg_req = 1'b1; dbg_we = 1'b1; dbg_addr = 5'd24; dbg_wdata = 8'h80;
        c0 = cyc;
        for (int k = 0; k < 8; k++)
            sb.push_back('{own[k], c0 + 2 + 3 * k, own[k] ? dbg_rd_m : cpu_rd_m});
        ni = 0; cn = 0; dn = 0;
        for (int t = 0; t < 30 && (cpu_req || dbg_req); t++) begin
            @(negedge clk);
            if (mem_en) begin
                n_cmp++;
                if (ni > 7 || mem_wdata !== ew[ni & 7]) begin
                    n_bad++;
                    $display("FAIL b2b_issue%0d got wdata=%h required %h", ni, mem_wdata, ew[ni & 7]);
                end
                ni++;
            end
            if (cpu_ack) begin
                cn++;
                if (cn == 4) cpu_req = 1'b0;
                else begin cpu_wdata = 8'(8'h40 + cn); cpu_addr = 5'(16 + cn); end
            end
            if (dbg_ack) begin
                dn++;
                if (dn == 4) dbg_req = 1'b0;
                else begin dbg_wdata = 8'(8'h80 + dn); dbg_addr = 5'(24 + dn); end
            end
        end
        n_cmp++;
        if (ni != 8 || cn != 4 || dn != 4) begin
            n_bad++;
            $display("FAIL b2b_count got issues=%0d cpu_acks=%0d dbg_acks=%0d required 8 4 4", ni, cn, dn);
        end
    endtask

    task automatic test_reset_mid;
        int acks;
        @(posedge clk); #1;
        cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 5'd7;
        repeat (3) @(negedge clk);
        n_cmp++;
        if ({busy, mem_en} !== 2'b10) begin
            n_bad++;
            $display("FAIL rstmid_wait got busy/en=%b required 10", {busy, mem_en});
        end
        rst = 1'b1;
        #1;
        n_cmp++;
        if ({mem_en, mem_we, cpu_ack, dbg_ack, busy} !== 5'b0) begin
            n_bad++;
            $display("FAIL rstmid_ctrl got %b required 00000", {mem_en, mem_we, cpu_ack, dbg_ack, busy});
        end
        n_cmp++;
        if ({cpu_rdata, dbg_rdata, mem_addr, mem_wdata} !== 29'd0) begin
            n_bad++;
            $display("FAIL rstmid_data got cpu_rd=%h dbg_rd=%h addr=%h wdata=%h required all 0", cpu_rdata, dbg_rdata, mem_addr, mem_wdata);
        end
        cpu_req = 1'b0;
        cpu_rd_m = '0;
        dbg_rd_m = '0;
        @(negedge clk);
        rst = 1'b0;
        acks = 0;
        repeat (8) begin
            @(negedge clk);
            if (cpu_ack) acks++;
        end
        n_cmp++;
        if (acks != 0 || cpu_rdata !== 8'h00) begin
            n_bad++;
            $display("FAIL rstmid_after got acks=%0d cpu_rd=%h required 0 00", acks, cpu_rdata);
        end
    endtask

    task automatic test_req_drop;
        int c0, acks, ens;
        @(posedge clk); #1;
        cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 5'd9;
        c0 = cyc;
        cpu_rd_m = rom(5'd9);
        sb.push_back('{1'b0, c0 + 2 + LAT, cpu_rd_m});
        repeat (2) @(negedge clk);
        n_cmp++;
        if ({mem_en, mem_we, mem_addr} !== {1'b1, 1'b0, 5'd9}) begin
            n_bad++;
            $display("FAIL drop_issue got en=%b we=%b addr=%h required 1 0 09", mem_en, mem_we, mem_addr);
        end
        cpu_req = 1'b0; cpu_we = 1'b1; cpu_addr = 5'd1;
        #1;
        n_cmp++;
        if (cpu_stall !== 1'b0) begin
            n_bad++;
            $display("FAIL drop_stall got %b required 0", cpu_stall);
        end
        acks = 0; ens = 0;
        repeat (10) begin
            @(negedge clk);
            if (cpu_ack) acks++;
            if (mem_en) ens++;
        end
        n_cmp++;
        if (acks != 1 || ens != 0 || cpu_rdata !== rom(5'd9)) begin
            n_bad++;
            $display("FAIL drop_result got acks=%0d extra_en=%0d cpu_rd=%h required 1 0 %h", acks, ens, cpu_rdata, rom(5'd9));
        end
    endtask

    initial begin
        #20000;
        $display("FAIL watchdog timeout at cyc=%0d", cyc);
        $fatal(1);
    end

    initial begin
        rst = 1'b1;
        cpu_req = 1'b0; cpu_we = 1'b0; cpu_addr = '0; cpu_wdata = '0;
        dbg_req = 1'b0; dbg_we = 1'b0; dbg_addr = '0; dbg_wdata = '0;
        test_reset;
        test_cpu_write;
        test_dbg_read;
        test_tie;
        test_back_to_back;
        test_reset_mid;
        test_req_drop;
        repeat (3) @(negedge clk);
        n_cmp++;
        if (sb.size() != 0) begin
            n_bad++;
            $display("FAIL sb_drain got %0d outstanding acks required 0", sb.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
